// File: rtl/mer_pkg.sv
// Shared FSM state type, accumulator width helpers and the 4-ASK power scale for the MER window meter.
package mer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DIV   = 2'd2,
      PWR   = 2'd3
   } mer_state_e;

   // 4-ASK mean power is 1.25 * ref^2, formed as sq + (sq >> PWR_SCALE_SHIFT)
   localparam int unsigned PWR_SCALE_SHIFT = 2;

   function automatic int unsigned abs_acc_w(input int unsigned data_w, input int unsigned window_log2);
      return data_w - 1 + window_log2;
   endfunction

   function automatic int unsigned sq_acc_w(input int unsigned data_w, input int unsigned window_log2);
      return 2 * data_w + window_log2;
   endfunction

   function automatic int unsigned dc_acc_w(input int unsigned data_w, input int unsigned window_log2);
      return data_w + window_log2;
   endfunction

endpackage

// File: rtl/mer_window_meter_if.sv
// Measurement bus of the MER window meter: symbol-rate inputs, window control and registered results.
interface mer_window_meter_if #(
   parameter int unsigned DATA_W      = 18,
   parameter int unsigned WINDOW_LOG2 = 10
);
   logic                          i_sym_clk_ena;
   logic                          i_start;
   logic                          i_continuous;
   logic signed [DATA_W-1:0]      i_decision_variable;
   logic signed [DATA_W-1:0]      i_error;
   logic                          o_busy;
   logic                          o_result_valid;
   logic signed [DATA_W-1:0]      o_reference_level;
   logic        [2*DATA_W:0]      o_mapper_out_power;
   logic        [2*DATA_W-1:0]    o_avg_sq_error;
   logic signed [DATA_W-1:0]      o_dc_error;
   logic        [WINDOW_LOG2-1:0] o_sample_count;

   modport master (
      output i_sym_clk_ena, i_start, i_continuous, i_decision_variable, i_error,
      input  o_busy, o_result_valid, o_reference_level, o_mapper_out_power,
             o_avg_sq_error, o_dc_error, o_sample_count
   );

   modport slave (
      input  i_sym_clk_ena, i_start, i_continuous, i_decision_variable, i_error,
      output o_busy, o_result_valid, o_reference_level, o_mapper_out_power,
             o_avg_sq_error, o_dc_error, o_sample_count
   );
endinterface

// File: rtl/mer_accumulator.sv
// Clear/enable accumulator; the input is sign- or zero-extended to the accumulator width.
module mer_accumulator #(
   parameter int unsigned IN_W   = 8,
   parameter int unsigned ACC_W  = 16,
   parameter bit          SIGNED = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [IN_W-1:0]  i_din,
   output logic [ACC_W-1:0] o_acc
);
   logic [ACC_W-1:0] w_din_ext;
   logic [ACC_W-1:0] r_acc;

   generate
      if (SIGNED) begin : g_sext
         assign w_din_ext = ACC_W'($signed(i_din));
      end else begin : g_zext
         assign w_din_ext = ACC_W'(i_din);
      end
   endgenerate

   // Clear wins over enable so a restart discards a coincident sample
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_acc <= '0;
      end else if (i_clr) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= r_acc + w_din_ext;
      end
   end

   assign o_acc = r_acc;
endmodule

// File: rtl/mer_window_meter.sv
// MER measurement engine: windowed mean |dv|, mean error^2, 4-ASK mapper power and optional mean error.
// Define MER_DC_EST_EN to build the DC error accumulator; otherwise dc_error is tied to zero.
module mer_window_meter
   import mer_pkg::*;
#(
   parameter int unsigned DATA_W      = 18,
   parameter int unsigned WINDOW_LOG2 = 10
) (
   input  logic               i_sys_clk,
   input  logic               i_reset,
   mer_window_meter_if.slave  bus
);
   localparam int unsigned ABS_W  = abs_acc_w(DATA_W, WINDOW_LOG2);
   localparam int unsigned SQ_W   = sq_acc_w(DATA_W, WINDOW_LOG2);
   localparam int unsigned PWR_W  = 2 * DATA_W + 1;
   localparam logic signed [DATA_W-1:0] DV_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   mer_state_e r_state, w_next_state;

   logic                          w_acc_clr, w_acc_en, w_div, w_pwr, w_last;
   logic signed [DATA_W-1:0]      w_dv, w_err;
   logic        [DATA_W-2:0]      w_dv_abs;
   logic signed [2*DATA_W-1:0]    w_err_sq_s;
   logic        [2*DATA_W-1:0]    w_err_sq, w_ref_sq;
   logic        [ABS_W-1:0]       w_abs_acc;
   logic        [SQ_W-1:0]        w_sq_acc;

   logic                          r_busy, r_result_valid;
   logic        [WINDOW_LOG2-1:0] r_sample_count;
   logic        [DATA_W-1:0]      r_ref_level;
   logic        [PWR_W-1:0]       r_mapper_pwr;
   logic        [2*DATA_W-1:0]    r_avg_sq_err;

   assign w_dv  = bus.i_decision_variable;
   assign w_err = bus.i_error;
   assign w_last = (r_sample_count == '1);

   // Most negative dv has no positive twin; clamp to full scale
   assign w_dv_abs   = (w_dv == DV_MIN) ? '1
                     : (w_dv[DATA_W-1] ? (DATA_W-1)'(-w_dv) : (DATA_W-1)'(w_dv));
   assign w_err_sq_s = (2*DATA_W)'(w_err) * (2*DATA_W)'(w_err);
   assign w_err_sq   = w_err_sq_s;
   assign w_ref_sq   = (2*DATA_W)'(r_ref_level) * (2*DATA_W)'(r_ref_level);

   always_ff @(posedge i_sys_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (bus.i_start) w_next_state = ACCUM;
         ACCUM:   if (!bus.i_start && bus.i_sym_clk_ena && w_last) w_next_state = DIV;
         DIV:     w_next_state = PWR;
         PWR:     w_next_state = bus.i_continuous ? ACCUM : IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Datapath controls: clear on every entry into ACCUM, including a restart from ACCUM itself
   always_comb begin
      w_acc_clr = 1'b0;
      w_acc_en  = 1'b0;
      w_div     = 1'b0;
      w_pwr     = 1'b0;
      case (r_state)
         IDLE:    w_acc_clr = bus.i_start;
         ACCUM: begin
            w_acc_clr = bus.i_start;
            w_acc_en  = bus.i_sym_clk_ena && !bus.i_start;
         end
         DIV:     w_div = 1'b1;
         PWR: begin
            w_pwr     = 1'b1;
            w_acc_clr = bus.i_continuous;
         end
         default: ;
      endcase
   end

   mer_accumulator #(.IN_W(DATA_W-1), .ACC_W(ABS_W), .SIGNED(1'b0)) u_abs_acc (
      .i_clk(i_sys_clk), .i_reset(i_reset), .i_clr(w_acc_clr), .i_en(w_acc_en),
      .i_din(w_dv_abs), .o_acc(w_abs_acc)
   );

   mer_accumulator #(.IN_W(2*DATA_W), .ACC_W(SQ_W), .SIGNED(1'b0)) u_sq_acc (
      .i_clk(i_sys_clk), .i_reset(i_reset), .i_clr(w_acc_clr), .i_en(w_acc_en),
      .i_din(w_err_sq), .o_acc(w_sq_acc)
   );

   always_ff @(posedge i_sys_clk) begin
      if (i_reset) begin
         r_busy         <= 1'b0;
         r_result_valid <= 1'b0;
         r_sample_count <= '0;
         r_ref_level    <= '0;
         r_mapper_pwr   <= '0;
         r_avg_sq_err   <= '0;
      end else begin
         r_busy         <= (w_next_state != IDLE);
         r_result_valid <= w_pwr;
         if (w_acc_clr) begin
            r_sample_count <= '0;
         end else if (w_acc_en) begin
            r_sample_count <= r_sample_count + WINDOW_LOG2'(1);
         end
         if (w_div) begin
            r_ref_level  <= DATA_W'(w_abs_acc >> WINDOW_LOG2);
            r_avg_sq_err <= (2*DATA_W)'(w_sq_acc >> WINDOW_LOG2);
         end
         if (w_pwr) begin
            r_mapper_pwr <= PWR_W'(w_ref_sq) + PWR_W'(w_ref_sq >> PWR_SCALE_SHIFT);
         end
      end
   end

`ifdef MER_DC_EST_EN
   localparam int unsigned DC_W = dc_acc_w(DATA_W, WINDOW_LOG2);

   logic signed [DC_W-1:0]   w_dc_acc;
   logic signed [DATA_W-1:0] r_dc_error;

   mer_accumulator #(.IN_W(DATA_W), .ACC_W(DC_W), .SIGNED(1'b1)) u_dc_acc (
      .i_clk(i_sys_clk), .i_reset(i_reset), .i_clr(w_acc_clr), .i_en(w_acc_en),
      .i_din(w_err), .o_acc(w_dc_acc)
   );

   always_ff @(posedge i_sys_clk) begin
      if (i_reset) begin
         r_dc_error <= '0;
      end else if (w_div) begin
         r_dc_error <= DATA_W'(w_dc_acc >>> WINDOW_LOG2);
      end
   end

   assign bus.o_dc_error = r_dc_error;
`else
   assign bus.o_dc_error = '0;
`endif

   assign bus.o_busy             = r_busy;
   assign bus.o_result_valid     = r_result_valid;
   assign bus.o_sample_count     = r_sample_count;
   assign bus.o_reference_level  = r_ref_level;
   assign bus.o_mapper_out_power = r_mapper_pwr;
   assign bus.o_avg_sq_error     = r_avg_sq_err;
endmodule
